// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared types and constants for the servo command scheduler:
//   pos_t / byte_t  : 8-bit servo position and raw UART byte
//   HDR_BYTE        : command header (0xFF is never a legal position)
//   CENTER_POS      : reset / neutral servo position
//   parser_state_t  : command parser states
// -----------------------------------------------------------------------------
package servo_pkg;

    typedef logic [7:0] pos_t;
    typedef logic [7:0] byte_t;

    localparam byte_t HDR_BYTE   = 8'hFF;
    localparam pos_t  CENTER_POS = 8'd128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_CH  = 2'd1,
        GET_POS = 2'd2
    } parser_state_t;

endpackage : servo_pkg

// File: rtl/servo_cmd_scheduler_if.sv
// -----------------------------------------------------------------------------
// servo_cmd_scheduler_if
// Byte stream from the UART receiver into the servo command scheduler.
//   RxD_data_ready : one-cycle strobe, RxD_data is valid
//   RxD_data       : received UART byte
// Modports: master = UART receiver side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface servo_cmd_scheduler_if;
    import servo_pkg::*;

    logic  RxD_data_ready;
    byte_t RxD_data;

    modport master (output RxD_data_ready, output RxD_data);
    modport slave  (input  RxD_data_ready, input  RxD_data);

endinterface : servo_cmd_scheduler_if

// File: rtl/servo_slew_step.sv
// -----------------------------------------------------------------------------
// servo_slew_step
// Combinational next position for one channel at a frame apply edge.
//   i_pos      : currently applied position
//   i_target   : commanded target position
//   o_next_pos : position to apply at the next frame boundary
// Build option SERVO_SLEW_LIMIT_EN: when defined, the position moves toward
// the target by at most STEP per frame and lands exactly on it once within
// STEP; when undefined, the target passes straight through and STEP is unused.
// -----------------------------------------------------------------------------
module servo_slew_step
    import servo_pkg::*;
#(
    parameter int STEP = 2
) (
    input  pos_t i_pos,
    input  pos_t i_target,
    output pos_t o_next_pos
);

`ifdef SERVO_SLEW_LIMIT_EN
    // Both operands are zero-extended so the 9-bit signed difference covers
    // the full -254..+254 range without wrapping.
    logic signed [8:0] w_diff;
    logic        [8:0] w_mag;

    assign w_diff = $signed({1'b0, i_target}) - $signed({1'b0, i_pos});
    assign w_mag  = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        o_next_pos = i_pos;
        if (w_mag <= 9'(STEP)) begin
            o_next_pos = i_target;
        end else if (!w_diff[8]) begin
            o_next_pos = i_pos + 8'(STEP);
        end else begin
            o_next_pos = i_pos - 8'(STEP);
        end
    end
`else
    // Current position and step size do not affect a pass-through; they are
    // folded into a sink so the port list stays identical in both builds.
    logic w_unused;
    assign w_unused   = ^{i_pos, 8'(STEP)};
    assign o_next_pos = i_target;
`endif

endmodule : servo_slew_step

// File: rtl/servo_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// servo_cmd_scheduler
// Parses 3-byte servo commands (0xFF, channel, position) from a UART byte
// stream, holds one target per channel and applies targets to the PWM-facing
// position outputs only at frame boundaries, so a pulse never changes
// mid-period. Owns the frame timebase.
//   clk        : system clock
//   rst_n      : synchronous reset, active-low
//   rx         : UART byte stream (servo_cmd_scheduler_if.slave)
//   pos_out    : applied positions, channel i at [8i+7:8i]
//   pos_valid  : per-channel strobe, high in the frame_sync cycle if changed
//   frame_sync : high for the first cycle of each frame
//   cmd_err    : one-cycle strobe, command rejected (bad channel number)
// Build option SERVO_SLEW_LIMIT_EN limits movement to STEP per frame
// (see servo_slew_step).
// -----------------------------------------------------------------------------
module servo_cmd_scheduler
    import servo_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    servo_cmd_scheduler_if.slave  rx,
    output logic [NUM_CH*8-1:0]   pos_out,
    output logic [NUM_CH-1:0]     pos_valid,
    output logic                  frame_sync,
    output logic                  cmd_err
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // ---------------------------------------------------------------- timebase
    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_frame_end;

    assign w_frame_end = (r_frame_cnt == CNT_W'(FRAME_CYCLES - 1));
    assign frame_sync  = (r_frame_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------ parser
    parser_state_t r_state;
    parser_state_t w_state_nxt;
    logic [CH_W-1:0] r_ch;
    logic            w_ch_load;
    logic            w_tgt_we;
    logic            w_err_nxt;
    logic            r_cmd_err;
    logic            w_is_hdr;
    logic            w_ch_ok;

    assign w_is_hdr = (rx.RxD_data == HDR_BYTE);
    assign w_ch_ok  = (rx.RxD_data < 8'(NUM_CH));

    always_comb begin
        w_state_nxt = r_state;
        w_ch_load   = 1'b0;
        w_tgt_we    = 1'b0;
        w_err_nxt   = 1'b0;
        if (rx.RxD_data_ready) begin
            unique case (r_state)
                IDLE: begin
                    if (w_is_hdr) w_state_nxt = GET_CH;
                end
                GET_CH: begin
                    // A header here restarts the command; staying put is the resync.
                    if (w_is_hdr) begin
                        w_state_nxt = GET_CH;
                    end else if (w_ch_ok) begin
                        w_ch_load   = 1'b1;
                        w_state_nxt = GET_POS;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                GET_POS: begin
                    // A header drops the partial command silently and restarts.
                    if (w_is_hdr) begin
                        w_state_nxt = GET_CH;
                    end else begin
                        w_tgt_we    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_err <= w_err_nxt;
            if (w_ch_load) begin
                r_ch <= rx.RxD_data[CH_W-1:0];
            end
        end
    end

    assign cmd_err = r_cmd_err;

    // ----------------------------------------------------------------- targets
    pos_t r_target [NUM_CH];

    // NOTE: the target and position arrays are reset element by element: they
    // are a handful of flops, not a RAM, and must come up at CENTER_POS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i] <= CENTER_POS;
            end
        end else begin
            // Later writes simply overwrite earlier ones: last command wins.
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_tgt_we && (r_ch == CH_W'(i))) begin
                    r_target[i] <= rx.RxD_data;
                end
            end
        end
    end

    // ------------------------------------------------------- frame apply point
    pos_t              r_pos [NUM_CH];
    pos_t              w_next_pos [NUM_CH];
    logic [NUM_CH-1:0] r_pos_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_slew_step #(
            .STEP (STEP)
        ) u_slew_step (
            .i_pos      (r_pos[g]),
            .i_target   (r_target[g]),
            .o_next_pos (w_next_pos[g])
        );
        assign pos_out[8*g +: 8] = r_pos[g];
    end

    // Targets are read as registered before the wrap edge, so a target written
    // on that same edge waits for the following frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pos[i] <= CENTER_POS;
            end
            r_pos_valid <= '0;
        end else begin
            r_pos_valid <= '0;
            if (w_frame_end) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_pos[i]       <= w_next_pos[i];
                    r_pos_valid[i] <= (w_next_pos[i] != r_pos[i]);
                end
            end
        end
    end

    assign pos_valid = r_pos_valid;

endmodule : servo_cmd_scheduler
